deviation_scheduler: RTL and testbench

- Time-shares one absolute-value unit across N_CH sensor channels of the health-check datapath.
- Per granted request, computes the saturated magnitude |sample − nominal| and flags an alarm when it exceeds a threshold.
- Sits between the sensor capture registers and the display/alarm logic.
- Keeps a saturating count of alarms.

---
 rtl/deviation_scheduler_if.sv | 26 ++
 rtl/deviation_scheduler.sv | 102 ++++++++++
 tb/tb_deviation_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/deviation_scheduler_if.sv
// deviation_scheduler_if: request/operand/result bundle between sensor channels and the deviation scheduler
interface deviation_scheduler_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int CH_W = $clog2(N_CH);
    logic [N_CH-1:0]       req;
    logic [N_CH*WIDTH-1:0] sample_in;
    logic [WIDTH-1:0]      nominal_in;
    logic [WIDTH-1:0]      threshold_in;
    logic [N_CH-1:0]       grant;
    logic                  busy;
    logic                  result_valid;
    logic [CH_W-1:0]       result_ch;
    logic [WIDTH-1:0]      result_abs;
    logic                  alarm;
    logic [7:0]            alarm_count;
    modport master (
        output req, sample_in, nominal_in, threshold_in,
        input  grant, busy, result_valid, result_ch, result_abs, alarm, alarm_count
    );
    modport slave (
        input  req, sample_in, nominal_in, threshold_in,
        output grant, busy, result_valid, result_ch, result_abs, alarm, alarm_count
    );
endinterface

// File: rtl/deviation_scheduler.sv
// deviation_scheduler: shares one |sample - nominal| unit across N_CH channels; SCHED_FIXED_PRIORITY_EN selects fixed priority instead of round robin
module deviation_scheduler #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic reset,
    deviation_scheduler_if.slave bus
);
    localparam int CH_W = $clog2(N_CH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    logic [WIDTH-1:0]      op_s;
    logic [WIDTH-1:0]      op_n;
    logic [CH_W-1:0]       sel;
    logic signed [WIDTH:0] diff;
    logic [WIDTH:0]        mag_full;
    logic [WIDTH-1:0]      mag;

`ifdef SCHED_FIXED_PRIORITY_EN
    // lowest-index requester wins; scanning downward leaves the lowest one in sel
    always_comb begin
        sel = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (bus.req[i]) sel = CH_W'(i);
    end
`else
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] idx;
    logic            found;
    // round robin: first requester at or after rr_ptr, wrapping through the power-of-two index space
    always_comb begin
        sel   = rr_ptr;
        idx   = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = rr_ptr + CH_W'(i);
            if (!found && bus.req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
`endif

    // one extra bit keeps the difference exact; a magnitude needing that bit saturates to all ones
    assign diff     = $signed({op_s[WIDTH-1], op_s}) - $signed({op_n[WIDTH-1], op_n});
    assign mag_full = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign mag      = mag_full[WIDTH] ? {WIDTH{1'b1}} : mag_full[WIDTH-1:0];

    // IDLE -> CALC -> DONE sequencer with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            op_s             <= '0;
            op_n             <= '0;
            bus.grant        <= '0;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result_ch    <= '0;
            bus.result_abs   <= '0;
            bus.alarm        <= 1'b0;
            bus.alarm_count  <= '0;
`ifndef SCHED_FIXED_PRIORITY_EN
            rr_ptr           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.result_valid <= 1'b0;
                    if (bus.req != '0) begin
                        op_s      <= bus.sample_in[sel*WIDTH +: WIDTH];
                        op_n      <= bus.nominal_in;
                        bus.grant <= N_CH'(1) << sel;
                        bus.busy  <= 1'b1;
                        state     <= CALC;
`ifndef SCHED_FIXED_PRIORITY_EN
                        rr_ptr    <= sel + 1'b1;
`endif
                    end
                end
                CALC: begin
                    bus.result_abs   <= mag;
                    bus.alarm        <= mag > bus.threshold_in;
                    bus.result_ch    <= CH_W'($clog2(32'(bus.grant)));
                    bus.grant        <= '0;
                    bus.result_valid <= 1'b1;
                    state            <= DONE;
                end
                default: begin
                    if (bus.alarm && bus.alarm_count != 8'hFF)
                        bus.alarm_count <= bus.alarm_count + 8'd1;
                    bus.result_valid <= 1'b0;
                    bus.busy         <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_deviation_scheduler.sv
// tb_deviation_scheduler: directed vectors with a result scoreboard for deviation_scheduler
module tb_deviation_scheduler;
    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int CH_W  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;
    int   exp_count = 0;
    logic [CH_W+WIDTH:0] exp_q[$];

    deviation_scheduler_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();
    deviation_scheduler #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    // free-running clock
    always #5 clk = ~clk;

    // cycle counter used to measure grant spacing
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: every result strobe must match the oldest expected result
    always @(negedge clk) begin
        if (!reset && bus.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: ch %0d abs %0d with nothing expected", bus.result_ch, bus.result_abs);
            end else begin
                logic [CH_W+WIDTH:0] e;
                e = exp_q.pop_front();
                check("result_ch", 32'(bus.result_ch), 32'(e[CH_W+WIDTH:WIDTH+1]));
                check("result_abs", 32'(bus.result_abs), 32'(e[WIDTH:1]));
                check("alarm", 32'(bus.alarm), 32'(e[0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_timeout: got no grant expected one within 12 cycles");
        end
    endtask

    task automatic push_exp(input int ch, input logic [WIDTH-1:0] a, input logic al);
        exp_q.push_back({CH_W'(ch), a, al});
        if (al && exp_count < 255) exp_count++;
    endtask

    task automatic do_single(input int ch, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] n,
                             input logic [WIDTH-1:0] thr, input logic [WIDTH-1:0] ea, input logic eal);
        logic ok;
        bus.sample_in[ch*WIDTH +: WIDTH] = s;
        bus.nominal_in = n;
        bus.threshold_in = thr;
        push_exp(ch, ea, eal);
        bus.req = N_CH'(1) << ch;
        wait_grant(ok);
        if (ok) begin
            check("single_grant", 32'(bus.grant), 32'(N_CH'(1) << ch));
            check("busy_calc", 32'(bus.busy), 1);
        end
        bus.req = '0;
        tick(2);
        check("alarm_count", 32'(bus.alarm_count), 32'(exp_count));
        check("busy_idle", 32'(bus.busy), 0);
    endtask

    task automatic check_reset_state();
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_result_valid", 32'(bus.result_valid), 0);
        check("rst_result_ch", 32'(bus.result_ch), 0);
        check("rst_result_abs", 32'(bus.result_abs), 0);
        check("rst_alarm", 32'(bus.alarm), 0);
        check("rst_alarm_count", 32'(bus.alarm_count), 0);
    endtask

    initial begin
        logic ok;
        int prev;
        int ech;
        logic [WIDTH-1:0] rr_abs[4];
        logic rr_alarm[4];
        rr_abs   = '{8'd10, 8'd10, 8'd100, 8'd100};
        rr_alarm = '{1'b0, 1'b0, 1'b1, 1'b1};
        bus.req = '0;
        bus.sample_in = '0;
        bus.nominal_in = '0;
        bus.threshold_in = '0;
        tick(2);
        check_reset_state();
        reset = 1'b0;
        tick(1);

        do_single(0, 8'd50, 8'd20, 8'd25, 8'd30, 1'b1);
        do_single(1, 8'h80, 8'd127, 8'd254, 8'd255, 1'b1);
        do_single(3, 8'hFB, 8'd5, 8'd25, 8'd10, 1'b0);
        do_single(2, 8'd60, 8'd20, 8'd40, 8'd40, 1'b0);
        do_single(1, 8'd20, 8'd60, 8'd39, 8'd40, 1'b1);

        bus.sample_in[2*WIDTH +: WIDTH] = 8'd90;
        bus.nominal_in = 8'd0;
        bus.req = 4'b0100;
        wait_grant(ok);
        if (ok) check("abort_grant", 32'(bus.grant), 32'h4);
        bus.req = '0;
        reset = 1'b1;
        tick(1);
        check_reset_state();
        reset = 1'b0;
        exp_count = 0;
        tick(4);

        bus.sample_in = {8'h9C, 8'd100, 8'hF6, 8'd10};
        bus.nominal_in = 8'd0;
        bus.threshold_in = 8'd50;
        for (int k = 0; k < 5; k++) begin
`ifdef SCHED_FIXED_PRIORITY_EN
            ech = 0;
`else
            ech = k % 4;
`endif
            push_exp(ech, rr_abs[ech], rr_alarm[ech]);
        end
        bus.req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
`ifdef SCHED_FIXED_PRIORITY_EN
            ech = 0;
`else
            ech = k % 4;
`endif
            wait_grant(ok);
            if (ok) begin
                check("arb_grant", 32'(bus.grant), 32'(N_CH'(1) << ech));
                if (k > 0) check("grant_spacing", 32'(cycle - prev), 3);
                prev = cycle;
            end
            if (k == 4) bus.req = '0;
        end
        tick(2);
        check("arb_alarm_count", 32'(bus.alarm_count), 32'(exp_count));

        bus.sample_in[0 +: WIDTH] = 8'h7F;
        bus.nominal_in = 8'h80;
        bus.threshold_in = 8'd0;
        bus.req = 4'b0001;
        for (int k = 0; k < 260; k++) begin
            push_exp(0, 8'd255, 1'b1);
            wait_grant(ok);
            if (k == 259) bus.req = '0;
        end
        tick(2);
        check("sat_alarm_count", 32'(bus.alarm_count), 255);
        tick(3);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
